// File: rtl/vu_pkg.sv
// Shared VU-meter definitions: band geometry, level-vector packing and controller states.
// Also used by the VGA bar renderer, so the band-to-slice mapping lives here.
package vu_pkg;

  localparam int N_BANDS = 16;
  localparam int LVL_W   = 8;
  localparam int VEC_W   = N_BANDS * LVL_W;

  typedef enum logic {ACC, PUB} vu_state_e;

  // Band 0 occupies the most significant byte of the packed vector.
  function automatic logic [6:0] band_lsb(input logic [3:0] band);
    return 7'((N_BANDS - 1 - int'(band)) * LVL_W);
  endfunction

endpackage

// File: rtl/vu_band_decay.sv
// Combinational per-band frame step: take a new peak and reload the hold,
// otherwise count the hold down, then decay toward zero without wrapping.
module vu_band_decay
  import vu_pkg::*;
#(
  parameter int unsigned DECAY       = 4,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic [LVL_W-1:0] acc,
  input  logic [LVL_W-1:0] held,
  input  logic [3:0]       hcnt,
  output logic [LVL_W-1:0] held_nxt,
  output logic [3:0]       hcnt_nxt
);

  localparam logic [LVL_W-1:0] DECAY_L = LVL_W'(DECAY);
  localparam logic [3:0]       HOLD_L  = 4'(HOLD_FRAMES);

  always_comb begin
    held_nxt = held;
    hcnt_nxt = hcnt;
    if (acc >= held) begin
      held_nxt = acc;
      hcnt_nxt = HOLD_L;
    end else if (hcnt != 4'd0) begin
      hcnt_nxt = hcnt - 4'd1;
    end else begin
      held_nxt = (held > DECAY_L) ? (held - DECAY_L) : '0;
    end
  end

endmodule

// File: rtl/vu_level_gen.sv
// VU-meter level producer: per-frame peak capture, hold/decay, and a tear-free
// publish of the packed level vector once per vsync.
//   state | meaning
//   ACC   | accepting samples, tracking per-band peaks, waiting for vsync
//   PUB   | stepping one band per cycle through hold/decay into the shadow
module vu_level_gen
  import vu_pkg::*;
#(
  parameter int unsigned DECAY       = 4,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vs,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_band,
  input  logic [LVL_W-1:0] s_level,
  output logic [VEC_W-1:0] o_data,
  output logic             o_upd,
  output logic             o_miss
);

  vu_state_e        state;
  logic             vs_q;
  logic [3:0]       idx;
  logic [LVL_W-1:0] acc  [N_BANDS];
  logic [LVL_W-1:0] held [N_BANDS];
  logic [3:0]       hcnt [N_BANDS];
  logic [VEC_W-1:0] shadow;
  logic [VEC_W-1:0] pub_vec;
  logic [LVL_W-1:0] held_nxt;
  logic [3:0]       hcnt_nxt;
  logic             frame_edge;

  assign frame_edge = vs_q & ~i_vs;

  vu_band_decay #(
    .DECAY       (DECAY),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_decay (
    .acc      (acc[idx]),
    .held     (held[idx]),
    .hcnt     (hcnt[idx]),
    .held_nxt (held_nxt),
    .hcnt_nxt (hcnt_nxt)
  );

  // Merging the current band here lets the last band land in o_data on the same edge.
  always_comb begin
    pub_vec = shadow;
    pub_vec[band_lsb(idx) +: LVL_W] = held_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ACC;
      vs_q    <= 1'b1;
      idx     <= '0;
      shadow  <= '0;
      o_data  <= '0;
      o_upd   <= 1'b0;
      o_miss  <= 1'b0;
      s_ready <= 1'b0;
      for (int b = 0; b < N_BANDS; b++) begin
        acc[b]  <= '0;
        held[b] <= '0;
        hcnt[b] <= '0;
      end
    end else begin
      vs_q  <= i_vs;
      o_upd <= 1'b0;
      case (state)
        ACC: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready && (s_level > acc[s_band])) begin
            acc[s_band] <= s_level;
          end
          if (frame_edge) begin
            state   <= PUB;
            idx     <= '0;
            s_ready <= 1'b0;
          end
        end
        PUB: begin
          held[idx] <= held_nxt;
          hcnt[idx] <= hcnt_nxt;
          acc[idx]  <= '0;
          shadow    <= pub_vec;
          if (frame_edge) begin
            o_miss <= 1'b1;
          end
          if (idx == 4'(N_BANDS - 1)) begin
            state   <= ACC;
            s_ready <= 1'b1;
            o_upd   <= 1'b1;
            o_data  <= pub_vec;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: doc/vu_level_gen.md
Name: vu_level_gen

Overview:
Producer side of the VU-meter bar interface. It accepts per-band level samples over a valid/ready stream and tracks the peak of each of 16 bands per video frame. Once per frame it applies peak-hold and decay, then publishes the packed 128-bit level vector that the VGA bar renderer consumes. Updates are frame-synchronous: the whole vector changes once, at the vsync edge, so bars never tear mid-frame.

Parameters:
DECAY, 4, amount subtracted from a held level per frame once its hold expires (8-bit, saturating at 0)
HOLD_FRAMES, 8, frames a new peak is held before decay starts (1..15)

Ports:
clk  in  1  system clock (same clock as the VGA timing generator)
rst  in  1  asynchronous, active-low reset
i_vs  in  1  vsync from the VGA timing generator, active-low pulse
s_valid  in  1  level sample valid
s_ready  out  1  block can accept a sample
s_band  in  4  band index; 0-7 left channel (top half of screen), 8-15 right channel (bottom half)
s_level  in  8  sample magnitude, 0..255 (255 = full bar)
o_data  out  128  packed levels; band i at bits [127-8i -: 8], so band 0 is [127:120] and band 15 is [7:0]
o_upd  out  1  one-cycle pulse on the cycle o_data changes
o_miss  out  1  sticky flag: a frame edge arrived while publishing

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - o_data=0, o_upd=0, o_miss=0, s_ready=0.
  - All peak accumulators, held levels and hold counters cleared to 0.
  - vs_q=1, state=ACC.
  - s_ready goes to 1 on the first clock after reset release.
- Frame edge: vs_q is i_vs registered. An edge is detected on a clock where vs_q=1 and i_vs=0.
- States:
  - ACC: s_ready=1. On s_valid&&s_ready, acc[s_band] <= max(acc[s_band], s_level). Frame edge seen -> PUB, idx=0.
  - PUB: s_ready=0. Processes one band per cycle, idx 0..15. After idx=15 -> ACC.
- Per-band update in PUB (band i):
  - If acc[i] >= held[i]: held <= acc[i]; hcnt <= HOLD_FRAMES.
  - Else if hcnt != 0: hcnt <= hcnt-1.
  - Else: held <= (held > DECAY) ? held-DECAY : 0.
  - Then acc[i] <= 0.
- Commit: held values are written to a shadow vector during PUB. The shadow is copied to o_data in a single cycle.
- Timing, with the frame edge sampled at clock k:
  - PUB occupies cycles k+1..k+16.
  - o_data is updated and o_upd=1 in cycle k+17.
  - s_ready returns to 1 in cycle k+17.
- Simultaneous sample and edge: a sample accepted in cycle k (s_ready=1) counts toward the frame being published.
- Frame edge during PUB: the edge is ignored (no second publish) and o_miss is set to 1. o_miss is cleared only by reset.
- s_valid held while s_ready=0: no transfer. The sample must be held by the source (standard valid/ready).
- Arithmetic: all values are 8-bit unsigned, with no wrap. The decay subtraction saturates at 0. hcnt is 4-bit.
- Bands with no samples in a frame see acc=0, so they follow the hold-then-decay path.

Decomposition:
- Shared package vu_pkg holds:
  - N_BANDS=16 and LVL_W=8.
  - Band-to-bit-slice mapping function (shared with the VGA bar renderer).
  - State enum {ACC, PUB}.
- One natural sub-module: vu_band_decay. It is the combinational per-band hold/decay step; inputs acc, held, hcnt; outputs next held and next hcnt.
- The edge detector and FSM stay in the top module.

Test Plan:
- Reset, then one frame with no samples -> o_data=0, o_upd pulses once 17 cycles after the vsync falling edge; o_miss=0.
- Band 0 gets level 200, band 15 gets 37, then one vsync edge -> o_data[127:120]=200, o_data[7:0]=37, other bytes 0; s_ready low for exactly 16 cycles.
- Band 3 = 100 in frame 1, no samples afterward, DECAY=4, HOLD_FRAMES=8 -> byte 3 reads 100 for frames 1..9, then 96, 92, ... and reaches 0 by frame 34 (saturates, never wraps).
- Band 5 receives samples 10, 250, 30 in one frame -> published 250; a new sample of 251 in the next frame overrides the held value immediately and reloads the hold.
- Second vsync edge injected 5 cycles into PUB -> o_miss=1, only one o_upd pulse. Sample asserted in the edge cycle is included; s_valid held through PUB transfers at k+17.
- rst asserted mid-PUB (cycle k+8) -> o_data, o_upd, o_miss, acc and held all clear at once, with no o_upd pulse afterward.
